// File: rtl/cpu_pkg.sv
// Shared opcode, sub-op and FSM encodings for the cpu_mc_irq multi-cycle processor.
package cpu_pkg;

    localparam logic [3:0] OP_JMP  = 4'h0;
    localparam logic [3:0] OP_JZ   = 4'h1;
    localparam logic [3:0] OP_JNZ  = 4'h2;
    localparam logic [3:0] OP_CALL = 4'h3;
    localparam logic [3:0] OP_SYS  = 4'h4;
    localparam logic [3:0] OP_LI   = 4'h5;
    localparam logic [3:0] OP_IN   = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_INC = 3'd6;
    localparam logic [2:0] ALU_DEC = 3'd7;

    localparam logic [1:0] SYS_RET  = 2'b00;
    localparam logic [1:0] SYS_RETI = 2'b01;
    localparam logic [1:0] SYS_EI   = 2'b10;
    localparam logic [1:0] SYS_DI   = 2'b11;

    typedef enum logic {StFetch, StExec} state_e;

endpackage

// File: rtl/cpu_stack.sv
// Return-address stack: push onto a full stack or pop from an empty one is refused
// and reported with a single-cycle error pulse.
module cpu_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             ovf_o,
    output logic             unf_o
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SPW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q, sp_d, sp_m1;
    logic             full, empty;

    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);
    assign sp_m1 = sp_q - 1'b1;
    // An empty stack pops as zero.
    assign top_o = empty ? '0 : mem_q[sp_m1[AW-1:0]];

    always_comb begin
        sp_d  = sp_q;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (push_i) begin
            if (full) ovf_o = 1'b1;
            else      sp_d  = sp_q + 1'b1;
        end else if (pop_i) begin
            if (empty) unf_o = 1'b1;
            else       sp_d  = sp_m1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
            if (push_i && !full) mem_q[sp_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/cpu_mc_irq.sv
// Two-state (fetch/execute) CPU with a 16-entry register file, I/O ports, a call stack
// and one maskable level-sensitive interrupt.
module cpu_mc_irq
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PC_W        = 10,
    parameter int unsigned NIN         = 4,
    parameter int unsigned NOUT        = 4,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned IRQ_VEC     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [15:0]           imem_data,
    input  logic [NIN*WIDTH-1:0]  in_bus,
    output logic [NOUT*WIDTH-1:0] out_bus,
    output logic [NOUT-1:0]       out_stb,
    input  logic                  irq,
    output logic                  irq_ack,
    output logic                  stack_err
);
    state_e                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic                  ie_q, ie_d, z_q, z_d, ack_q, ack_d, err_q;
    logic [NOUT*WIDTH-1:0] out_q, out_d;
    logic [NOUT-1:0]       stb_q, stb_d;
    logic [WIDTH-1:0]      rf_q [16];

    logic [3:0]       op, rd, ra, rb;
    logic [7:0]       imm;
    logic [PC_W-1:0]  addr, push_data, stk_top;
    logic [WIDTH-1:0] a_val, b_val, d_val, alu_res, in_val, wdata;
    logic [WIDTH+7:0] imm_ext;
    logic             we, push, pop, stk_ovf, stk_unf;

    assign op      = imem_data[15:12];
    assign rd      = imem_data[11:8];
    assign ra      = imem_data[7:4];
    assign rb      = imem_data[3:0];
    assign imm     = imem_data[7:0];
    assign addr    = imem_data[PC_W-1:0];
    assign a_val   = rf_q[ra];
    assign b_val   = rf_q[rb];
    assign d_val   = rf_q[rd];
    assign imm_ext = {{WIDTH{1'b0}}, imm};

    always_comb begin
        alu_res = '0;
        unique case (op[2:0])
            ALU_ADD: alu_res = a_val + b_val;
            ALU_SUB: alu_res = a_val - b_val;
            ALU_AND: alu_res = a_val & b_val;
            ALU_OR:  alu_res = a_val | b_val;
            ALU_XOR: alu_res = a_val ^ b_val;
            ALU_NOT: alu_res = ~a_val;
            ALU_INC: alu_res = a_val + 1'b1;
            ALU_DEC: alu_res = a_val - 1'b1;
        endcase
    end

    always_comb begin
        in_val = '0;
        for (int unsigned k = 0; k < NIN; k++) begin
            if (imm == 8'(k)) in_val = in_bus[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ie_d      = ie_q;
        z_d       = z_q;
        out_d     = out_q;
        stb_d     = '0;
        ack_d     = 1'b0;
        we        = 1'b0;
        wdata     = '0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = pc_q;
        unique case (state_q)
            StFetch: begin
                // Interrupt entry discards the word being fetched and stays in fetch.
                if (irq && ie_q) begin
                    push  = 1'b1;
                    pc_d  = PC_W'(IRQ_VEC);
                    ie_d  = 1'b0;
                    ack_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_q + 1'b1;
                if (op[3]) begin
                    we    = 1'b1;
                    wdata = alu_res;
                    z_d   = (alu_res == '0);
                end else begin
                    unique case (op)
                        OP_JMP: pc_d = addr;
                        OP_JZ:  if (z_q) pc_d = addr;
                        OP_JNZ: if (!z_q) pc_d = addr;
                        OP_CALL: begin
                            push      = 1'b1;
                            push_data = pc_q + 1'b1;
                            pc_d      = addr;
                        end
                        OP_SYS: begin
                            unique case (imm[1:0])
                                SYS_RET:  begin pop = 1'b1; pc_d = stk_top; end
                                SYS_RETI: begin pop = 1'b1; pc_d = stk_top; ie_d = 1'b1; end
                                SYS_EI:   ie_d = 1'b1;
                                SYS_DI:   ie_d = 1'b0;
                            endcase
                        end
                        OP_LI: begin we = 1'b1; wdata = imm_ext[WIDTH-1:0]; end
                        OP_IN: begin we = 1'b1; wdata = in_val; end
                        OP_OUT: begin
                            for (int unsigned k = 0; k < NOUT; k++) begin
                                if (imm == 8'(k)) begin
                                    out_d[k*WIDTH +: WIDTH] = d_val;
                                    stb_d[k]                = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = StFetch;
        endcase
    end

    cpu_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_stack (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .top_o   (stk_top),
        .ovf_o   (stk_ovf),
        .unf_o   (stk_unf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ie_q    <= 1'b0;
            z_q     <= 1'b0;
            out_q   <= '0;
            stb_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ie_q    <= ie_d;
            z_q     <= z_d;
            out_q   <= out_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            err_q   <= err_q | stk_ovf | stk_unf;
            if (we && rd != 4'd0) rf_q[rd] <= wdata;
        end
    end

    assign imem_addr = pc_q;
    assign out_bus   = out_q;
    assign out_stb   = stb_q;
    assign irq_ack   = ack_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_cpu_mc_irq.sv
// Bench for cpu_mc_irq: directed programs plus random programs, checked step by step
// against an instruction-level reference model.
module tb_cpu_mc_irq;
    localparam int WIDTH = 8, PC_W = 10, NIN = 4, NOUT = 4, DEPTH = 8, IRQ_VEC = 1;
    localparam int MASK = (1 << WIDTH) - 1;
    localparam int PCN  = 1 << PC_W;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [PC_W-1:0]       imem_addr;
    logic [15:0]           imem_data = '0;
    logic [NIN*WIDTH-1:0]  in_bus = '0;
    logic [NOUT*WIDTH-1:0] out_bus;
    logic [NOUT-1:0]       out_stb;
    logic                  irq = 1'b0;
    logic                  irq_ack;
    logic                  stack_err;

    int n_cmp = 0;
    int n_fail = 0;

    cpu_mc_irq #(
        .WIDTH       (WIDTH),
        .PC_W        (PC_W),
        .NIN         (NIN),
        .NOUT        (NOUT),
        .STACK_DEPTH (DEPTH),
        .IRQ_VEC     (IRQ_VEC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .in_bus    (in_bus),
        .out_bus   (out_bus),
        .out_stb   (out_stb),
        .irq       (irq),
        .irq_ack   (irq_ack),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [PCN];
    always @(posedge clk) imem_data <= mem[imem_addr];

    // Reference model state
    int m_pc, m_ie, m_z, m_err;
    int m_r [16];
    int m_out [NOUT];
    int m_stk [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] a,
                                        input logic [7:0] b);
        return {op, a, b};
    endfunction

    function automatic logic [15:0] enc_j(input logic [3:0] op, input int target);
        return {op, 2'b00, 10'(target)};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ie = 0; m_z = 0; m_err = 0;
        for (int i = 0; i < 16; i++) m_r[i] = 0;
        for (int i = 0; i < NOUT; i++) m_out[i] = 0;
        m_stk.delete();
    endtask

    task automatic m_push(input int v);
        if (m_stk.size() == DEPTH) m_err = 1;
        else m_stk.push_back(v);
    endtask

    task automatic m_pop(output int v);
        if (m_stk.size() == 0) begin
            m_err = 1;
            v = 0;
        end else begin
            v = m_stk.pop_back();
        end
    endtask

    task automatic m_wr(input int rd, input int v);
        if (rd != 0) m_r[rd] = v & MASK;
    endtask

    // One architectural event: interrupt entry (1 cycle) or one instruction (2 cycles).
    task automatic model_step(output int cyc, output logic [NOUT-1:0] stb, output logic ack);
        logic [15:0] ins;
        int op, rd, ra, rb, imm, tgt, nxt, res, v;
        stb = '0;
        ack = 1'b0;
        if (irq && m_ie != 0) begin
            m_push(m_pc);
            m_pc = IRQ_VEC;
            m_ie = 0;
            ack  = 1'b1;
            cyc  = 1;
            return;
        end
        cyc = 2;
        ins = mem[m_pc];
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:8]);
        ra  = int'(ins[7:4]);
        rb  = int'(ins[3:0]);
        imm = int'(ins[7:0]);
        tgt = int'(ins[PC_W-1:0]);
        nxt = (m_pc + 1) % PCN;
        m_pc = nxt;
        if (op >= 8) begin
            case (op - 8)
                0: res = m_r[ra] + m_r[rb];
                1: res = m_r[ra] - m_r[rb];
                2: res = m_r[ra] & m_r[rb];
                3: res = m_r[ra] | m_r[rb];
                4: res = m_r[ra] ^ m_r[rb];
                5: res = MASK - m_r[ra];
                6: res = m_r[ra] + 1;
                default: res = m_r[ra] - 1;
            endcase
            res = res & MASK;
            m_wr(rd, res);
            m_z = (res == 0) ? 1 : 0;
        end else begin
            case (op)
                0: m_pc = tgt;
                1: if (m_z != 0) m_pc = tgt;
                2: if (m_z == 0) m_pc = tgt;
                3: begin m_push(nxt); m_pc = tgt; end
                4: begin
                    case (imm % 4)
                        0: begin m_pop(v); m_pc = v; end
                        1: begin m_pop(v); m_pc = v; m_ie = 1; end
                        2: m_ie = 1;
                        default: m_ie = 0;
                    endcase
                end
                5: m_wr(rd, imm);
                6: m_wr(rd, (imm < NIN) ? int'(in_bus[imm*WIDTH +: WIDTH]) : 0);
                default: begin
                    if (imm < NOUT) begin
                        m_out[imm] = m_r[rd];
                        stb[imm]   = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic run_step();
        int cyc;
        logic [NOUT-1:0] stb;
        logic ack;
        logic [NOUT*WIDTH-1:0] eb;
        model_step(cyc, stb, ack);
        if (cyc == 2) begin
            tick();
            check_eq("mid_stb", 32'(out_stb), 32'(0));
            check_eq("mid_ack", 32'(irq_ack), 32'(0));
        end
        tick();
        for (int k = 0; k < NOUT; k++) eb[k*WIDTH +: WIDTH] = WIDTH'(m_out[k]);
        check_eq("pc", 32'(imem_addr), 32'(m_pc));
        check_eq("out_stb", 32'(out_stb), 32'(stb));
        check_eq("irq_ack", 32'(irq_ack), 32'(ack));
        check_eq("stack_err", 32'(stack_err), 32'(m_err));
        check_eq("out_bus", 32'(out_bus), 32'(eb));
    endtask

    task automatic do_reset();
        irq   = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < PCN; i++) mem[i] = '0;
    endtask

    function automatic logic [15:0] rand_ins();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'h6 || w[15:12] == 4'h7) w[7:0] = 8'($urandom_range(0, 5));
        return w;
    endfunction

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Arithmetic, OUT strobe, conditional jumps, out-of-range I/O ports.
        clear_mem();
        mem[0]     = enc(4'h5, 4'd1, 8'h05);
        mem[1]     = enc(4'h5, 4'd2, 8'h03);
        mem[2]     = enc(4'h8, 4'd3, 8'h12);
        mem[3]     = enc(4'h7, 4'd3, 8'd2);
        mem[4]     = enc(4'h9, 4'd4, 8'h11);
        mem[5]     = enc_j(4'h1, 'h020);
        mem['h20]  = enc(4'hE, 4'd4, 8'h40);
        mem['h21]  = enc_j(4'h2, 'h030);
        mem['h30]  = enc(4'h6, 4'd5, 8'd7);
        mem['h31]  = enc(4'h7, 4'd1, 8'd9);
        mem['h32]  = enc(4'h7, 4'd5, 8'd1);
        mem['h33]  = enc_j(4'h0, 'h033);
        in_bus = 32'hA5C3_96E1;
        do_reset();
        check_eq("rst_pc", 32'(imem_addr), 32'(0));
        check_eq("rst_out_bus", 32'(out_bus), 32'(0));
        check_eq("rst_out_stb", 32'(out_stb), 32'(0));
        check_eq("rst_irq_ack", 32'(irq_ack), 32'(0));
        check_eq("rst_stack_err", 32'(stack_err), 32'(0));
        repeat (4) run_step();
        check_eq("add_out_port2", 32'(out_bus[23:16]), 32'h08);
        check_eq("add_out_stb", 32'(out_stb), 32'b0100);
        repeat (2) run_step();
        check_eq("jz_taken", 32'(imem_addr), 32'h020);
        repeat (2) run_step();
        check_eq("jnz_taken", 32'(imem_addr), 32'h030);
        repeat (2) run_step();
        check_eq("out_bad_port_stb", 32'(out_stb), 32'(0));
        check_eq("out_bad_port_bus", 32'(out_bus), 32'h0008_0000);
        run_step();
        check_eq("in_bad_port", 32'(out_bus[15:8]), 32'h00);
        check_eq("in_bad_port_stb", 32'(out_stb), 32'b0010);
        repeat (2) run_step();

        // Nine nested calls into an eight-deep stack, then unwind.
        clear_mem();
        mem[0] = enc_j(4'h3, 'h100);
        mem[1] = enc(4'h4, 4'd0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            mem['h100 + 2*k] = enc_j(4'h3, 'h102 + 2*k);
            mem['h101 + 2*k] = enc(4'h4, 4'd0, 8'h00);
        end
        mem['h110] = enc(4'h4, 4'd0, 8'h00);
        do_reset();
        repeat (8) run_step();
        check_eq("call8_no_err", 32'(stack_err), 32'(0));
        run_step();
        check_eq("call9_err", 32'(stack_err), 32'(1));
        check_eq("call9_pc", 32'(imem_addr), 32'h110);
        for (int k = 0; k < 8; k++) begin
            run_step();
            check_eq("ret_lifo", 32'(imem_addr), (k < 7) ? 32'('h10D - 2*k) : 32'h001);
        end
        run_step();
        check_eq("ret_empty_pc", 32'(imem_addr), 32'(0));

        // Interrupt entry, RETI, and immediate retrigger with irq held high.
        clear_mem();
        mem[0]     = enc_j(4'h0, 'h040);
        mem[1]     = enc(4'h7, 4'd1, 8'd3);
        mem[2]     = enc(4'h4, 4'd0, 8'h01);
        mem['h40]  = enc(4'h5, 4'd1, 8'h11);
        mem['h41]  = enc(4'h4, 4'd0, 8'h02);
        mem['h42]  = enc(4'h5, 4'd2, 8'h22);
        mem['h43]  = enc_j(4'h0, 'h043);
        do_reset();
        repeat (2) run_step();
        irq = 1'b1;
        run_step();
        run_step();
        check_eq("irq_ack_pulse", 32'(irq_ack), 32'(1));
        check_eq("irq_vec_pc", 32'(imem_addr), 32'(IRQ_VEC));
        run_step();
        check_eq("isr_out_stb", 32'(out_stb), 32'b1000);
        run_step();
        check_eq("reti_pc", 32'(imem_addr), 32'h042);
        run_step();
        check_eq("retrigger_ack", 32'(irq_ack), 32'(1));
        check_eq("retrigger_pc", 32'(imem_addr), 32'(IRQ_VEC));
        irq = 1'b0;
        repeat (4) run_step();

        // Reset during the execute cycle of an OUT.
        clear_mem();
        mem[0] = enc(4'h5, 4'd1, 8'h5A);
        mem[1] = enc(4'h7, 4'd1, 8'd0);
        mem[2] = enc(4'h4, 4'd0, 8'h00);
        do_reset();
        repeat (4) run_step();
        check_eq("pre_rst_err", 32'(stack_err), 32'(1));
        tick();
        reset = 1'b1;
        tick();
        check_eq("rst_exec_stb", 32'(out_stb), 32'(0));
        check_eq("rst_exec_pc", 32'(imem_addr), 32'(0));
        check_eq("rst_exec_bus", 32'(out_bus), 32'(0));
        check_eq("rst_exec_err", 32'(stack_err), 32'(0));
        reset = 1'b0;
        model_reset();
        repeat (3) run_step();

        // Random programs with random irq level and input ports.
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < PCN; i++) mem[i] = rand_ins();
            do_reset();
            for (int s = 0; s < 500; s++) begin
                if ($urandom_range(0, 5) == 0) irq = ~irq;
                in_bus = $urandom;
                run_step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
